// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spikes over a 2^WINDOW_LOG2 window (rate) and, with SPIKE_ISI_EN defined, measures inter-spike intervals.
// Latency: rate_out/rate_valid update on the window-end edge itself; isi_out/isi_valid update on the spike edge itself.
// Backpressure: none; rate_valid and isi_valid are single-cycle strobes that the consumer must sample or lose.
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       spike_in,
    output logic [7:0] rate_out,
    output logic       rate_valid,
    output logic [7:0] isi_out,
    output logic       isi_valid,
    output logic       isi_sat
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Last window position is N-1, which is all ones for a power-of-two window.
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
    localparam logic [WINDOW_LOG2-1:0] WIN_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

    state_t                 state_q;
    state_t                 state_d;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [7:0]             spk_cnt;
    logic [8:0]             spk_sum;
    logic [7:0]             spk_sum_sat;
    logic                   counting;
    logic                   win_last;

    // Only edges in COUNT with en high advance the window; the IDLE->COUNT edge is never counted.
    assign counting = (state_q == COUNT) && en;
    assign win_last = (win_cnt == WIN_LAST);

    // Running count including this edge's spike; the 9th bit flags overflow past 255.
    assign spk_sum     = {1'b0, spk_cnt} + {8'd0, spike_in};
    assign spk_sum_sat = spk_sum[8] ? 8'hFF : spk_sum[7:0];

    // State register; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enable high leaves IDLE, enable low abandons the partial window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = COUNT;
            COUNT:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window and spike counters; wrap to zero at window end so windows are back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end else if (counting) begin
            if (win_last) begin
                win_cnt <= '0;
                spk_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_ONE;
                spk_cnt <= spk_sum_sat;
            end
        end else begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end
    end

    // Rate output: publish the saturated total on the window-end edge, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_out   <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (counting && win_last) begin
                rate_out   <= spk_sum_sat;
                rate_valid <= 1'b1;
            end
        end
    end

`ifdef SPIKE_ISI_EN
    logic [7:0] isi_cnt;
    logic       have_prev;

    // ISI tracker: restart at 1 on each spike, report the gap once a previous spike exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_cnt   <= '0;
            have_prev <= 1'b0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
            isi_sat   <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (counting) begin
                if (spike_in) begin
                    isi_cnt   <= 8'd1;
                    have_prev <= 1'b1;
                    if (have_prev) begin
                        isi_out   <= isi_cnt;
                        isi_sat   <= (isi_cnt == 8'hFF);
                        isi_valid <= 1'b1;
                    end
                end else if (isi_cnt != 8'hFF) begin
                    isi_cnt <= isi_cnt + 8'd1;
                end
            end else begin
                isi_cnt   <= '0;
                have_prev <= 1'b0;
            end
        end
    end
`else
    assign isi_out   = '0;
    assign isi_valid = 1'b0;
    assign isi_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a 16-cycle window instance for rate/ISI/enable/reset cases
// and a 512-cycle window instance for count saturation.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       spike_in;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic [7:0] isi_out;
    logic       isi_valid;
    logic       isi_sat;

    logic       en9;
    logic       spk9;
    logic [7:0] rate9;
    logic       valid9;
    logic [7:0] isi9;
    logic       isi_valid9;
    logic       isi_sat9;

    int tests = 0;
    int fails = 0;

`ifdef SPIKE_ISI_EN
    localparam bit ISI = 1'b1;
`else
    localparam bit ISI = 1'b0;
`endif

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_LOG2(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
        .isi_sat    (isi_sat)
    );

    spike_rate_decoder #(.WINDOW_LOG2(9)) dut9 (
        .clk        (clk),
        .rst        (rst),
        .en         (en9),
        .spike_in   (spk9),
        .rate_out   (rate9),
        .rate_valid (valid9),
        .isi_out    (isi9),
        .isi_valid  (isi_valid9),
        .isi_sat    (isi_sat9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s);
        spike_in = s;
        tick();
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected ISI value: the measured gap when the feature is built, otherwise the tied-off zero.
    function automatic logic [7:0] iv(input logic [7:0] v);
        return ISI ? v : 8'd0;
    endfunction

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        spike_in = 1'b0;
        en9      = 1'b0;
        spk9     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_rate",      rate_out, 0);
        chk("rst_valid",     rate_valid, 0);
        chk("rst_isi",       isi_out, 0);
        chk("rst_isi_valid", isi_valid, 0);
        chk("rst_isi_sat",   isi_sat, 0);
        chk("rst_rate9",     rate9, 0);
        chk("rst_valid9",    valid9, 0);
        chk("rst_isi_valid9", isi_valid9, 0);
        rst = 1'b0;

        // Periodic train: spike every 4th counted edge from edge 1, two windows
        en = 1'b1;
        step(1'b0);
        for (int k = 1; k <= 32; k++) begin
            step((k - 1) % 4 == 0);
            chk("per_valid", rate_valid, (k % 16) == 0);
            if (k % 16 == 0) chk("per_rate", rate_out, 4);
            if (k == 1) chk("per_isi_first", isi_valid, 0);
            if (k == 5) begin
                chk("per_isi_valid", isi_valid, ISI);
                chk("per_isi_out", isi_out, iv(4));
            end
        end

        // Enable drop: partial window of 9 edges with 3 spikes is discarded
        en = 1'b0;
        step(1'b0);
        chk("drop0_valid", rate_valid, 0);
        chk("drop0_rate", rate_out, 4);
        en = 1'b1;
        step(1'b1);
        for (int k = 1; k <= 9; k++) begin
            step(k <= 3);
            if (k == 2) begin
                chk("drop_isi_valid", isi_valid, ISI);
                chk("drop_isi_out", isi_out, iv(1));
            end
        end
        en = 1'b0;
        step(1'b1);
        chk("drop_valid", rate_valid, 0);
        chk("drop_rate_hold", rate_out, 4);
        step(1'b0);
        en = 1'b1;
        step(1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(k == 5 || k == 16);
            chk("redo_valid", rate_valid, k == 16);
            if (k == 15) chk("redo_rate_hold", rate_out, 4);
            if (k == 5) chk("redo_isi_first", isi_valid, 0);
            if (k == 16) begin
                chk("redo_rate", rate_out, 2);
                chk("redo_isi_valid", isi_valid, ISI);
                chk("redo_isi_out", isi_out, iv(11));
            end
        end

        // Spike only on the window-end edge
        for (int k = 1; k <= 16; k++) begin
            step(k == 16);
            chk("end_valid", rate_valid, k == 16);
            if (k == 16) begin
                chk("end_rate", rate_out, 1);
                chk("end_isi_valid", isi_valid, ISI);
                chk("end_isi_out", isi_out, iv(16));
                chk("end_isi_sat", isi_sat, 0);
            end
        end

        // Reset mid-window
        for (int k = 1; k <= 5; k++) step(1'b1);
        rst = 1'b1;
        step(1'b0);
        chk("mrst_rate",      rate_out, 0);
        chk("mrst_valid",     rate_valid, 0);
        chk("mrst_isi",       isi_out, 0);
        chk("mrst_isi_valid", isi_valid, 0);
        chk("mrst_isi_sat",   isi_sat, 0);
        rst = 1'b0;
        en  = 1'b0;
        step(1'b1);
        step(1'b1);
        chk("idle_valid", rate_valid, 0);
        chk("idle_isi_valid", isi_valid, 0);
        en = 1'b1;
        step(1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(k == 3 || k == 4);
            chk("post_valid", rate_valid, k == 16);
            if (k == 4) begin
                chk("post_isi_valid", isi_valid, ISI);
                chk("post_isi_out", isi_out, iv(1));
            end
            if (k == 16) chk("post_rate", rate_out, 2);
        end

        // ISI: spikes on counted edges 10, 17, 400
        en = 1'b0;
        step(1'b0);
        en = 1'b1;
        step(1'b0);
        for (int k = 1; k <= 400; k++) begin
            step(k == 10 || k == 17 || k == 400);
            if (k == 10) chk("isi_first", isi_valid, 0);
            if (k == 16) begin
                chk("isi_w1_valid", rate_valid, 1);
                chk("isi_w1_rate", rate_out, 1);
            end
            if (k == 17) begin
                chk("isi17_valid", isi_valid, ISI);
                chk("isi17_out", isi_out, iv(7));
                chk("isi17_sat", isi_sat, 0);
            end
            if (k == 18) chk("isi18_valid", isi_valid, 0);
            if (k == 399) begin
                chk("isi399_hold", isi_out, iv(7));
                chk("isi399_rate", rate_out, 0);
            end
            if (k == 400) begin
                chk("isi400_valid", isi_valid, ISI);
                chk("isi400_out", isi_out, iv(255));
                chk("isi400_sat", isi_sat, ISI);
                chk("isi400_rvalid", rate_valid, 1);
                chk("isi400_rate", rate_out, 1);
            end
        end
        en = 1'b0;

        // Saturation with a 512-cycle window and spike held high
        en9  = 1'b1;
        spk9 = 1'b1;
        tick();
        for (int k = 1; k <= 1024; k++) begin
            tick();
            chk("sat_valid", valid9, (k % 512) == 0);
            if (k == 511) chk("sat_rate_pre", rate9, 0);
            if (k % 512 == 0) chk("sat_rate", rate9, 255);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
